axis_delay_ctrl: RTL and testbench
==================================

AXIS_DELAY_CTRL -- requirements
Module: axis_delay_ctrl

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32: width of all tdata buses.
REQ-002 Parameter CNTR_WIDTH, default 32: width of cfg values, counters and status.
REQ-003 aclk  in  1  single clock; all logic on rising edge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 cfg_delay  in  CNTR_WIDTH  FIFO words to accumulate before output starts.
REQ-006 cfg_length  in  CNTR_WIDTH  output words per run; 0 = endless.
REQ-007 trig  in  1  start pulse.
REQ-008 stop  in  1  abort pulse.
REQ-009 sts_state  out  2  state code: IDLE=0, FILL=1, RUN=2, DRAIN=3.
REQ-010 sts_occupancy  out  CNTR_WIDTH  FIFO word count.
REQ-011 sts_out_count  out  CNTR_WIDTH  output handshakes in the current run.
REQ-012 done  out  1  one-cycle pulse on DRAIN->IDLE.
REQ-013 s_axis_tready/tdata/tvalid  out/in/in  1/AXIS_TDATA_WIDTH/1  input stream.
REQ-014 m_axis_tready/tdata/tvalid  in/out/out  1/AXIS_TDATA_WIDTH/1  delayed output stream.
REQ-015 m_axis_fifo_tready/tdata/tvalid  in/out/out  1/AXIS_TDATA_WIDTH/1  FIFO write port.
REQ-016 s_axis_fifo_tready/tdata/tvalid  out/in/in  1/AXIS_TDATA_WIDTH/1  FIFO read port.

Function
REQ-017 Datapath shall be combinational: m_axis_fifo_tdata = s_axis_tdata and m_axis_tdata = s_axis_fifo_tdata, in every state.
REQ-018 IDLE: s_axis_tready=1 with input discarded; m_axis_fifo_tvalid=0, s_axis_fifo_tready=0, m_axis_tvalid=0.
REQ-019 IDLE + trig: latch cfg_delay and cfg_length, clear sts_out_count, go to FILL next cycle; stop in IDLE ignored.
REQ-020 FILL and RUN: m_axis_fifo_tvalid=s_axis_tvalid and s_axis_tready=m_axis_fifo_tready.
REQ-021 FILL: s_axis_fifo_tready=0, m_axis_tvalid=0.
REQ-022 FILL->RUN on the cycle after sts_occupancy reaches the latched delay; latched delay 0 -> RUN one cycle after entering FILL.
REQ-023 RUN: m_axis_tvalid=s_axis_fifo_tvalid and s_axis_fifo_tready=m_axis_tready.
REQ-024 RUN, latched length != 0: m_axis handshake bringing sts_out_count to the latched length -> DRAIN next cycle; that cycle's FIFO write still completes.
REQ-025 RUN, latched length 0: remain in RUN until stop; sts_out_count shall wrap modulo 2^CNTR_WIDTH.
REQ-026 stop in FILL or RUN -> DRAIN next cycle; handshakes in the stop cycle still count.
REQ-027 DRAIN: s_axis_tready=1 with input discarded, m_axis_fifo_tvalid=0, s_axis_fifo_tready=1 (FIFO contents discarded), m_axis_tvalid=0; trig and stop ignored.
REQ-028 DRAIN->IDLE the cycle after sts_occupancy is 0, with done=1 for exactly that IDLE-entry cycle; DRAIN entered at occupancy 0 exits after one cycle.
REQ-029 sts_occupancy: +1 on FIFO write handshake only, -1 on FIFO read handshake only, unchanged when both coincide.
REQ-030 cfg_delay/cfg_length changes outside the trig cycle shall not affect a run in progress.
REQ-031 cfg_delay shall be no greater than FIFO depth (integration rule); otherwise FILL stalls on backpressure, with no error flag.

Reset
REQ-032 areset high at a clock edge: state IDLE, sts_occupancy=0, sts_out_count=0, latched cfg=0, done=0; overrides trig/stop in that cycle.
REQ-033 The external FIFO shall be reset by the same areset so that occupancy 0 matches FIFO contents after reset mid-run.
REQ-034 Outputs during and directly after reset follow IDLE rules (REQ-018).

Verification
REQ-035 delay=4, length=8, tvalid/tready always 1, trig -> FILL 4 writes, RUN emits 8 words equal to inputs 0..7 in order, DRAIN removes 4, done pulses once, sts_state returns 0.
REQ-036 delay=0, length=3 -> RUN one cycle after FILL entry; 3 outputs then DRAIN with occupancy 0; done two cycles after last output.
REQ-037 length=0, random m_axis_tready -> output unbroken and in order; stop after 20 outputs -> DRAIN, FIFO emptied, sts_out_count=20.
REQ-038 delay=5, m_axis_fifo_tready low 3 cycles mid-FILL -> s_axis_tready low those cycles; RUN entered only after 5 writes.
REQ-039 trig and stop together in IDLE -> FILL; trig during RUN -> ignored, no cfg re-latch.
REQ-040 areset in RUN with occupancy 6 -> next cycle IDLE, occupancy 0, done 0, m_axis_tvalid 0.

Source files
------------

// File: rtl/axis_delay_ctrl.sv
// Purpose: gates an AXI-Stream through an external FIFO, holding output until cfg_delay words are buffered, then runs for cfg_length words (or endless) and drains.
// Latency: datapath is purely combinational; state and status update one cycle after the qualifying handshake or pulse.
// Backpressure: in FILL/RUN the input follows FIFO-write readiness and the FIFO read follows m_axis_tready; IDLE and DRAIN sink input unconditionally.
module axis_delay_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_delay,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic                        trig,
    input  logic                        stop,
    output logic [1:0]                  sts_state,
    output logic [CNTR_WIDTH-1:0]       sts_occupancy,
    output logic [CNTR_WIDTH-1:0]       sts_out_count,
    output logic                        done,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_fifo_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_fifo_tdata,
    output logic                        m_axis_fifo_tvalid,
    output logic                        s_axis_fifo_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_fifo_tdata,
    input  logic                        s_axis_fifo_tvalid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]            r_state;
    logic [CNTR_WIDTH-1:0] r_occ;
    logic [CNTR_WIDTH-1:0] r_cnt;
    logic [CNTR_WIDTH-1:0] r_delay;
    logic [CNTR_WIDTH-1:0] r_length;
    logic                  r_done;

    logic [1:0]            w_out_state;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_out_hs;
    logic [CNTR_WIDTH-1:0] w_occ_next;
    logic [CNTR_WIDTH-1:0] w_cnt_next;

    // While reset is held the handshake outputs already behave as IDLE,
    // so nothing downstream sees a stale RUN/FILL qualifier.
    assign w_out_state = areset ? ST_IDLE : r_state;

    // Data never passes through a register; only the qualifiers are gated.
    assign m_axis_fifo_tdata = s_axis_tdata;
    assign m_axis_tdata      = s_axis_fifo_tdata;

    assign sts_state     = r_state;
    assign sts_occupancy = r_occ;
    assign sts_out_count = r_cnt;
    assign done          = r_done;

    assign w_wr       = m_axis_fifo_tvalid & m_axis_fifo_tready;
    assign w_rd       = s_axis_fifo_tvalid & s_axis_fifo_tready;
    assign w_out_hs   = m_axis_tvalid & m_axis_tready;
    assign w_cnt_next = r_cnt + CNTR_WIDTH'(1);

    // Handshake qualifiers per state; input is sunk (ready, no FIFO write) in IDLE and DRAIN.
    always_comb begin
        s_axis_tready      = 1'b0;
        m_axis_fifo_tvalid = 1'b0;
        s_axis_fifo_tready = 1'b0;
        m_axis_tvalid      = 1'b0;
        case (w_out_state)
            ST_IDLE: begin
                s_axis_tready = 1'b1;
            end
            ST_FILL: begin
                m_axis_fifo_tvalid = s_axis_tvalid;
                s_axis_tready      = m_axis_fifo_tready;
            end
            ST_RUN: begin
                m_axis_fifo_tvalid = s_axis_tvalid;
                s_axis_tready      = m_axis_fifo_tready;
                m_axis_tvalid      = s_axis_fifo_tvalid;
                s_axis_fifo_tready = m_axis_tready;
            end
            default: begin
                s_axis_tready      = 1'b1;
                s_axis_fifo_tready = 1'b1;
            end
        endcase
    end

    // Occupancy after this edge: a simultaneous write and read cancel out.
    always_comb begin
        w_occ_next = r_occ;
        if (w_wr && !w_rd) begin
            w_occ_next = r_occ + CNTR_WIDTH'(1);
        end else if (w_rd && !w_wr) begin
            w_occ_next = r_occ - CNTR_WIDTH'(1);
        end
    end

    // Run-control FSM with occupancy tracking, output counting and the done pulse.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= ST_IDLE;
            r_occ    <= '0;
            r_cnt    <= '0;
            r_delay  <= '0;
            r_length <= '0;
            r_done   <= 1'b0;
        end else begin
            r_occ  <= w_occ_next;
            r_done <= 1'b0;
            // Output handshakes only exist in RUN; endless runs simply wrap.
            if (w_out_hs) begin
                r_cnt <= w_cnt_next;
            end
            case (r_state)
                ST_IDLE: begin
                    if (trig) begin
                        r_delay  <= cfg_delay;
                        r_length <= cfg_length;
                        r_cnt    <= '0;
                        r_state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Leave as soon as this edge brings occupancy up to the delay;
                    // a zero delay therefore spends exactly one cycle here.
                    if (stop) begin
                        r_state <= ST_DRAIN;
                    end else if (w_occ_next >= r_delay) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                    end else if ((r_length != '0) && w_out_hs && (w_cnt_next == r_length)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    if (r_occ == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_delay_ctrl.sv
module tb_axis_delay_ctrl;

    localparam int W     = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [CW-1:0] cfg_delay, cfg_length;
    logic          trig, stop;
    logic [1:0]    sts_state;
    logic [CW-1:0] sts_occupancy, sts_out_count;
    logic          done;
    logic          s_axis_tready, s_axis_tvalid;
    logic [W-1:0]  s_axis_tdata;
    logic          m_axis_tready, m_axis_tvalid;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_fifo_tready, m_axis_fifo_tvalid;
    logic [W-1:0]  m_axis_fifo_tdata;
    logic          s_axis_fifo_tready, s_axis_fifo_tvalid;
    logic [W-1:0]  s_axis_fifo_tdata;

    // Source, sink and external FIFO model state
    logic         src_on = 1'b0;
    logic         src_gap = 1'b0;
    logic         fifo_block = 1'b0;
    int           src_limit = 1000;
    int           src_sent = 0;
    logic [W-1:0] src_base = '0;
    logic [W-1:0] fifo_q[$];
    int           fifo_cnt = 0;
    logic [W-1:0] fifo_head = '0;

    // Statistics gathered by the monitor
    int cyc = 0, n_out = 0, n_done = 0, order_err = 0, exp_idx = 0;
    int occ_at_run = -1, occ_at_drain = -1, last_out_cyc = -1, done_cyc = -1;
    int n_st[4];
    logic [1:0] prev_st = 2'd0;

    int n_chk = 0, n_pass = 0;

    always #5 aclk = ~aclk;

    assign s_axis_tvalid      = src_on && (src_sent < src_limit) && !src_gap;
    assign s_axis_tdata       = src_base + W'(src_sent);
    assign m_axis_fifo_tready = !fifo_block && (fifo_cnt < DEPTH);
    assign s_axis_fifo_tvalid = (fifo_cnt != 0);
    assign s_axis_fifo_tdata  = fifo_head;

    axis_delay_ctrl #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset), .cfg_delay(cfg_delay), .cfg_length(cfg_length),
        .trig(trig), .stop(stop), .sts_state(sts_state), .sts_occupancy(sts_occupancy),
        .sts_out_count(sts_out_count), .done(done),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_fifo_tready(m_axis_fifo_tready), .m_axis_fifo_tdata(m_axis_fifo_tdata),
        .m_axis_fifo_tvalid(m_axis_fifo_tvalid),
        .s_axis_fifo_tready(s_axis_fifo_tready), .s_axis_fifo_tdata(s_axis_fifo_tdata),
        .s_axis_fifo_tvalid(s_axis_fifo_tvalid)
    );

    // Monitor: samples the just-finished cycle at the edge, then updates the FIFO and source models.
    always @(posedge aclk) begin
        logic         w_hs, r_hs, in_hs, on, rst;
        logic [W-1:0] wd;
        w_hs  = m_axis_fifo_tvalid && m_axis_fifo_tready;
        r_hs  = s_axis_fifo_tvalid && s_axis_fifo_tready;
        in_hs = s_axis_tvalid && s_axis_tready;
        wd    = m_axis_fifo_tdata;
        on    = src_on;
        rst   = areset;
        if (!rst) begin
            n_st[sts_state] = n_st[sts_state] + 1;
            if (sts_state == 2'd2 && prev_st != 2'd2) occ_at_run = int'(sts_occupancy);
            if (sts_state == 2'd3 && prev_st != 2'd3) occ_at_drain = int'(sts_occupancy);
            if (m_axis_tvalid && m_axis_tready) begin
                n_out++;
                last_out_cyc = cyc;
                if (m_axis_tdata !== src_base + W'(exp_idx)) order_err++;
                exp_idx++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        prev_st = sts_state;
        cyc++;
        #1;
        if (rst) begin
            fifo_q.delete();
        end else begin
            if (r_hs) void'(fifo_q.pop_front());
            if (w_hs) fifo_q.push_back(wd);
        end
        fifo_cnt  = fifo_q.size();
        fifo_head = (fifo_cnt != 0) ? fifo_q[0] : '0;
        if (!on) begin
            src_sent = 0;
            exp_idx  = 0;
        end else if (in_hs) begin
            src_sent++;
        end
    end

    task automatic next();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    task automatic clear_stats();
        n_out = 0; n_done = 0; order_err = 0;
        occ_at_run = -1; occ_at_drain = -1; last_out_cyc = -1; done_cyc = -1;
        for (int i = 0; i < 4; i++) n_st[i] = 0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sts_state == s) begin
                ok = 1'b1;
                break;
            end
            next();
        end
    endtask

    // Pulses trig with the given config, then scrambles cfg so only the latched copy matters.
    task automatic start_run(input int d, input int l, input int lim);
        cfg_delay  = CW'(d);
        cfg_length = CW'(l);
        src_limit  = lim;
        src_base   = $urandom;
        clear_stats();
        trig = 1'b1;
        next();
        trig       = 1'b0;
        src_on     = 1'b1;
        cfg_delay  = $urandom;
        cfg_length = $urandom_range(1, 3);
    endtask

    task automatic test_reset();
        areset = 1'b1; trig = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
        cfg_delay = '0; cfg_length = '0;
        for (int i = 0; i < 4; i++) n_st[i] = 0;
        sample();
        n_chk++; if (s_axis_tready !== 1'b1) $display("FAIL rst_during_s_tready: got %0b want 1", s_axis_tready); else n_pass++;
        n_chk++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_during_m_tvalid: got %0b want 0", m_axis_tvalid); else n_pass++;
        next(); next();
        areset = 1'b0;
        sample();
        n_chk++; if (sts_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", sts_state); else n_pass++;
        n_chk++; if (sts_occupancy !== '0) $display("FAIL rst_occ: got %0d want 0", sts_occupancy); else n_pass++;
        n_chk++; if (sts_out_count !== '0) $display("FAIL rst_count: got %0d want 0", sts_out_count); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else n_pass++;
        n_chk++; if (s_axis_fifo_tready !== 1'b0) $display("FAIL idle_fifo_rd: got %0b want 0", s_axis_fifo_tready); else n_pass++;
        // Offer input in IDLE: it must be accepted and discarded.
        next();
        src_base = $urandom; src_limit = 1000; src_on = 1'b1;
        sample();
        n_chk++; if (m_axis_fifo_tvalid !== 1'b0) $display("FAIL idle_fifo_wr: got %0b want 0", m_axis_fifo_tvalid); else n_pass++;
        n_chk++; if (s_axis_tready !== 1'b1) $display("FAIL idle_s_tready: got %0b want 1", s_axis_tready); else n_pass++;
        n_chk++; if (m_axis_fifo_tdata !== s_axis_tdata) $display("FAIL idle_datapath: got %0h want %0h", m_axis_fifo_tdata, s_axis_tdata); else n_pass++;
        repeat (3) next();
        src_on = 1'b0;
        sample();
        n_chk++; if (sts_occupancy !== '0) $display("FAIL idle_occ: got %0d want 0", sts_occupancy); else n_pass++;
        next();
    endtask

    task automatic test_basic_run();
        logic ok;
        m_axis_tready = 1'b1;
        start_run(4, 8, 1000);
        wait_state(2'd2, 50, ok);
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL basic_reach_run: got %0b want 1", ok); else n_pass++;
        n_chk++; if (m_axis_tdata !== s_axis_fifo_tdata) $display("FAIL basic_out_datapath: got %0h want %0h", m_axis_tdata, s_axis_fifo_tdata); else n_pass++;
        n_chk++; if (m_axis_fifo_tdata !== s_axis_tdata) $display("FAIL basic_in_datapath: got %0h want %0h", m_axis_fifo_tdata, s_axis_tdata); else n_pass++;
        next();
        wait_state(2'd0, 100, ok);
        src_on = 1'b0;
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL basic_reach_idle: got %0b want 1", ok); else n_pass++;
        n_chk++; if (done !== 1'b1) $display("FAIL basic_done_entry: got %0b want 1", done); else n_pass++;
        next();
        sample();
        n_chk++; if (done !== 1'b0) $display("FAIL basic_done_width: got %0b want 0", done); else n_pass++;
        n_chk++; if (n_st[1] !== 4) $display("FAIL basic_fill_cycles: got %0d want 4", n_st[1]); else n_pass++;
        n_chk++; if (n_st[2] !== 8) $display("FAIL basic_run_cycles: got %0d want 8", n_st[2]); else n_pass++;
        n_chk++; if (n_out !== 8) $display("FAIL basic_outputs: got %0d want 8", n_out); else n_pass++;
        n_chk++; if (order_err !== 0) $display("FAIL basic_order: got %0d errors want 0", order_err); else n_pass++;
        n_chk++; if (occ_at_drain !== 4) $display("FAIL basic_drain_occ: got %0d want 4", occ_at_drain); else n_pass++;
        n_chk++; if (n_st[3] !== 5) $display("FAIL basic_drain_cycles: got %0d want 5", n_st[3]); else n_pass++;
        n_chk++; if (n_done !== 1) $display("FAIL basic_done_count: got %0d want 1", n_done); else n_pass++;
        n_chk++; if (sts_out_count !== 8) $display("FAIL basic_out_count: got %0d want 8", sts_out_count); else n_pass++;
        n_chk++; if (sts_state !== 2'd0) $display("FAIL basic_final_state: got %0d want 0", sts_state); else n_pass++;
    endtask

    task automatic test_zero_delay();
        logic ok;
        m_axis_tready = 1'b1;
        start_run(0, 3, 3);
        wait_state(2'd0, 60, ok);
        src_on = 1'b0;
        next();
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL zd_reach_idle: got %0b want 1", ok); else n_pass++;
        n_chk++; if (n_st[1] !== 1) $display("FAIL zd_fill_cycles: got %0d want 1", n_st[1]); else n_pass++;
        n_chk++; if (n_out !== 3) $display("FAIL zd_outputs: got %0d want 3", n_out); else n_pass++;
        n_chk++; if (order_err !== 0) $display("FAIL zd_order: got %0d errors want 0", order_err); else n_pass++;
        n_chk++; if (occ_at_drain !== 0) $display("FAIL zd_drain_occ: got %0d want 0", occ_at_drain); else n_pass++;
        n_chk++; if (n_st[3] !== 1) $display("FAIL zd_drain_cycles: got %0d want 1", n_st[3]); else n_pass++;
        n_chk++; if (done_cyc - last_out_cyc !== 2) $display("FAIL zd_done_delay: got %0d want 2", done_cyc - last_out_cyc); else n_pass++;
    endtask

    task automatic test_endless_stop();
        logic ok;
        start_run(3, 0, 100000);
        for (int i = 0; i < 2000; i++) begin
            if (n_out == 20) break;
            m_axis_tready = 1'($urandom_range(0, 1));
            src_gap       = ($urandom_range(0, 3) == 0);
            next();
        end
        m_axis_tready = 1'b0;
        stop = 1'b1;
        next();
        stop = 1'b0; m_axis_tready = 1'b1; src_gap = 1'b0;
        sample();
        n_chk++; if (n_out !== 20) $display("FAIL endless_outputs: got %0d want 20", n_out); else n_pass++;
        n_chk++; if (sts_state !== 2'd3) $display("FAIL endless_stop_drain: got %0d want 3", sts_state); else n_pass++;
        n_chk++; if (occ_at_run !== 3) $display("FAIL endless_run_occ: got %0d want 3", occ_at_run); else n_pass++;
        next();
        wait_state(2'd0, 60, ok);
        src_on = 1'b0;
        next();
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL endless_reach_idle: got %0b want 1", ok); else n_pass++;
        n_chk++; if (sts_out_count !== 20) $display("FAIL endless_out_count: got %0d want 20", sts_out_count); else n_pass++;
        n_chk++; if (order_err !== 0) $display("FAIL endless_order: got %0d errors want 0", order_err); else n_pass++;
        n_chk++; if (fifo_cnt !== 0) $display("FAIL endless_fifo_empty: got %0d want 0", fifo_cnt); else n_pass++;
        n_chk++; if (sts_occupancy !== CW'(fifo_cnt)) $display("FAIL endless_occ_match: got %0d want %0d", sts_occupancy, fifo_cnt); else n_pass++;
        n_chk++; if (n_st[3] !== occ_at_drain + 1) $display("FAIL endless_drain_cycles: got %0d want %0d", n_st[3], occ_at_drain + 1); else n_pass++;
        n_chk++; if (n_done !== 1) $display("FAIL endless_done_count: got %0d want 1", n_done); else n_pass++;
    endtask

    task automatic test_fill_backpressure();
        logic ok;
        m_axis_tready = 1'b1;
        start_run(5, 4, 1000);
        repeat (2) next();
        fifo_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_chk++; if (s_axis_tready !== 1'b0) $display("FAIL bp_s_tready_%0d: got %0b want 0", i, s_axis_tready); else n_pass++;
            n_chk++; if (sts_state !== 2'd1) $display("FAIL bp_state_%0d: got %0d want 1", i, sts_state); else n_pass++;
            next();
        end
        fifo_block = 1'b0;
        wait_state(2'd0, 80, ok);
        src_on = 1'b0;
        next();
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL bp_reach_idle: got %0b want 1", ok); else n_pass++;
        n_chk++; if (occ_at_run !== 5) $display("FAIL bp_run_occ: got %0d want 5", occ_at_run); else n_pass++;
        n_chk++; if (n_st[1] !== 8) $display("FAIL bp_fill_cycles: got %0d want 8", n_st[1]); else n_pass++;
        n_chk++; if (n_out !== 4) $display("FAIL bp_outputs: got %0d want 4", n_out); else n_pass++;
        n_chk++; if (order_err !== 0) $display("FAIL bp_order: got %0d errors want 0", order_err); else n_pass++;
    endtask

    task automatic test_trig_stop_ignore();
        logic ok;
        m_axis_tready = 1'b1;
        cfg_delay = 2; cfg_length = 0; src_limit = 100000; src_base = $urandom;
        clear_stats();
        trig = 1'b1; stop = 1'b1;
        next();
        trig = 1'b0; stop = 1'b0; src_on = 1'b1;
        sample();
        n_chk++; if (sts_state !== 2'd1) $display("FAIL ts_idle_to_fill: got %0d want 1", sts_state); else n_pass++;
        next();
        wait_state(2'd2, 40, ok);
        cfg_length = 2; cfg_delay = 0; trig = 1'b1;
        next();
        trig = 1'b0;
        repeat (10) next();
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL ts_reach_run: got %0b want 1", ok); else n_pass++;
        n_chk++; if (sts_state !== 2'd2) $display("FAIL ts_still_run: got %0d want 2", sts_state); else n_pass++;
        n_chk++; if (sts_out_count !== CW'(n_out)) $display("FAIL ts_out_count: got %0d want %0d", sts_out_count, n_out); else n_pass++;
        next();
        stop = 1'b1;
        next();
        stop = 1'b0;
        wait_state(2'd0, 60, ok);
        src_on = 1'b0;
        next();
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL ts_reach_idle: got %0b want 1", ok); else n_pass++;
        n_chk++; if (order_err !== 0) $display("FAIL ts_order: got %0d errors want 0", order_err); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic ok;
        m_axis_tready = 1'b0;
        start_run(6, 0, 6);
        wait_state(2'd2, 50, ok);
        repeat (2) next();
        sample();
        n_chk++; if (ok !== 1'b1) $display("FAIL mr_reach_run: got %0b want 1", ok); else n_pass++;
        n_chk++; if (sts_occupancy !== 6) $display("FAIL mr_occ_before: got %0d want 6", sts_occupancy); else n_pass++;
        n_chk++; if (m_axis_tvalid !== 1'b1) $display("FAIL mr_tvalid_before: got %0b want 1", m_axis_tvalid); else n_pass++;
        next();
        areset = 1'b1;
        sample();
        n_chk++; if (m_axis_tvalid !== 1'b0) $display("FAIL mr_tvalid_during: got %0b want 0", m_axis_tvalid); else n_pass++;
        n_chk++; if (s_axis_tready !== 1'b1) $display("FAIL mr_s_tready_during: got %0b want 1", s_axis_tready); else n_pass++;
        next();
        areset = 1'b0; src_on = 1'b0;
        sample();
        n_chk++; if (sts_state !== 2'd0) $display("FAIL mr_state_after: got %0d want 0", sts_state); else n_pass++;
        n_chk++; if (sts_occupancy !== '0) $display("FAIL mr_occ_after: got %0d want 0", sts_occupancy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL mr_done_after: got %0b want 0", done); else n_pass++;
        n_chk++; if (m_axis_tvalid !== 1'b0) $display("FAIL mr_tvalid_after: got %0b want 0", m_axis_tvalid); else n_pass++;
        n_chk++; if (fifo_cnt !== 0) $display("FAIL mr_fifo_after: got %0d want 0", fifo_cnt); else n_pass++;
        m_axis_tready = 1'b1;
        next();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_zero_delay();
        test_endless_stop();
        test_fill_backpressure();
        test_trig_stop_ignore();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
